// File: rtl/rip_ro_pkg.sv
// Shared types and sizing helpers for the ring-oscillator edge counter.
package rip_ro_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        MEASURE,
        REPORT
    } ro_cnt_state_t;

    // Counter width able to index 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rip_sync_edge.sv
// Flop-chain synchronizer for an asynchronous input plus rising-edge detection.
module rip_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
        prev_d  = chain_q[STAGES-1];
        sync_o  = chain_q[STAGES-1];
        rise_o  = chain_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/rip_ro_counter.sv
// Ring-oscillator frequency counter: gates the oscillator, counts synchronized
// rising edges over a fixed window and reports the count via valid/ready.
module rip_ro_counter
    import rip_ro_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned COUNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ro_i,
    output logic                   ro_en_o,
    input  logic                   start_i,
    input  logic                   continuous_i,
    output logic                   busy_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   overflow_o
);

    localparam int unsigned WIN_W  = cnt_width(WINDOW_CYCLES);
    localparam int unsigned WARM_W = cnt_width(SYNC_STAGES + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);

    ro_cnt_state_t          state_q, state_d;
    logic [WARM_W-1:0]      warm_q, warm_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                   ovf_q, ovf_d, ovf_inc;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;
    logic                   ro_sync, ro_rise, edge_hit;

    rip_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rstn   (rstn),
        .d_i    (ro_i),
        .sync_o (ro_sync),
        .rise_o (ro_rise)
    );

    assign edge_hit = ro_rise & ro_sync;

    // Saturating increment: stick at all-ones and flag the overflow.
    always_comb begin
        cnt_inc = cnt_q;
        ovf_inc = ovf_q;
        if (edge_hit) begin
            if (&cnt_q) begin
                ovf_inc = 1'b1;
            end else begin
                cnt_inc = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        ro_en_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WARMUP;
                    warm_d  = '0;
                end
            end
            WARMUP: begin
                ro_en_o = 1'b1;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                win_d   = '0;
                if (warm_q == WARM_LAST) begin
                    state_d = MEASURE;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            MEASURE: begin
                ro_en_o = 1'b1;
                cnt_d   = cnt_inc;
                ovf_d   = ovf_inc;
                if (win_q == WIN_LAST) begin
                    count_d    = cnt_inc;
                    overflow_d = ovf_inc;
                    valid_d    = 1'b1;
                    state_d    = REPORT;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            REPORT: begin
                ro_en_o = continuous_i;
                if (ready_i) begin
                    valid_d = 1'b0;
                    if (continuous_i) begin
                        // Synchronizer stayed live, so no warm-up is needed.
                        state_d = MEASURE;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        win_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            warm_q     <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign valid_o    = valid_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
